// File: rtl/coef_bank_server_if.sv
// Coefficient server bus: filter read port, sample strobe and host load port.
//   master : filter/host side (drives address, strobe, load data, commit)
//   slave  : coef_bank_server (returns data, handshake status, bank index)
interface coef_bank_server_if #(
  parameter int CW = 18,
  parameter int AW = 7
);
  logic [AW-1:0] coefaddress;
  logic [CW-1:0] coefdata;
  logic          endata;
  logic          ld_start;
  logic          ld_valid;
  logic [CW-1:0] ld_data;
  logic          ld_ready;
  logic          commit;
  logic          ld_done;
  logic          ld_error;
  logic          bank_sel;

  modport master (
    output coefaddress, endata, ld_start, ld_valid, ld_data, commit,
    input  coefdata, ld_ready, ld_done, ld_error, bank_sel
  );

  modport slave (
    input  coefaddress, endata, ld_start, ld_valid, ld_data, commit,
    output coefdata, ld_ready, ld_done, ld_error, bank_sel
  );
endinterface

// File: rtl/coef_bank_server.sv
// coef_bank_server: double-banked coefficient store for the 65-tap FIR.
// The filter reads the active bank with 1-cycle latency; the host fills the
// shadow bank (~bank_sel) through a valid/ready port and commits it. The
// banks swap only on an endata strobe so a MAC pass never mixes two sets.
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   bus (slave)    : coefaddress/coefdata read port, endata swap strobe,
//                    ld_start/ld_valid/ld_data/ld_ready load port,
//                    commit request, ld_done/ld_error pulses, bank_sel
module coef_bank_server #(
  parameter int NTAPS = 65,
  parameter int CW    = 18,
  parameter int AW    = 7
) (
  input logic                clock,
  input logic                reset,
  coef_bank_server_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, FULL, PENDING} state_t;

  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

  state_t        state, state_n;
  logic [AW-1:0] wptr, wptr_n;
  logic          sel;
  logic          ready_q, done_q, err_q;
  logic          ready_n, done_n, err_n;
  logic          swap, wr_en;
  logic [CW-1:0] rdata;

  // Bank storage has no reset: contents persist across reset.
  logic [CW-1:0] bank0 [NTAPS];
  logic [CW-1:0] bank1 [NTAPS];

  // ---------------- control FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      wptr    <= '0;
      sel     <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      wptr    <= wptr_n;
      sel     <= sel ^ swap;
      ready_q <= ready_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    wptr_n  = wptr;
    wr_en   = 1'b0;
    swap    = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        // commit here is a no-op
        if (bus.ld_start) begin
          state_n = LOAD;
          wptr_n  = '0;
        end
      end
      LOAD: begin
        // Commit or restart both drop a same-cycle write; commit wins if
        // both arrive together so the host always hears about the abort.
        if (bus.commit) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else if (bus.ld_start) begin
          wptr_n = '0;
        end else if (bus.ld_valid && ready_q) begin
          wr_en = 1'b1;
          if (wptr == LAST) state_n = FULL;   // wptr parks at NTAPS-1
          else              wptr_n  = wptr + 1'b1;
        end
      end
      FULL: begin
        // A commit arriving with endata still waits for the next strobe.
        if (bus.commit) begin
          state_n = PENDING;
        end else if (bus.ld_start) begin
          state_n = LOAD;
          wptr_n  = '0;
        end
      end
      PENDING: begin
        if (bus.endata) begin
          swap    = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // Registered ready: high for every cycle spent in LOAD.
    ready_n = (state_n == LOAD);
  end

  // ---------------- shadow write ----------------
  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      if (sel) bank0[wptr] <= bus.ld_data;
      else     bank1[wptr] <= bus.ld_data;
    end
  end

  // ---------------- read path ----------------
  // Uses sel before the swap edge, so the read registered on the swap edge
  // still comes from the old bank.
  always_ff @(posedge clock) begin
    if (reset)                      rdata <= '0;
    else if (bus.coefaddress <= LAST) rdata <= sel ? bank1[bus.coefaddress] : bank0[bus.coefaddress];
    else                            rdata <= '0;
  end

  assign bus.coefdata = rdata;
  assign bus.ld_ready = ready_q;
  assign bus.ld_done  = done_q;
  assign bus.ld_error = err_q;
  assign bus.bank_sel = sel;

endmodule

// File: tb/tb_coef_bank_server.sv
module tb_coef_bank_server;
  localparam int NT = 65;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  coef_bank_server_if #(.CW(18), .AW(7)) bus ();

  coef_bank_server #(.NTAPS(NT), .CW(18), .AW(7)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Banks as plain arrays, load progress as a word count and a phase name.
  int  mbank  [2][NT];
  bit  mknown [2][NT];
  int  mcnt;
  bit  msel, mready, mdone, merr;
  bit  mloading, mfull, mpending;
  int  edata;
  bit  eknown;
  bit  mvalid = 0;

  initial forever begin
    @(negedge clock);
    if (mvalid) begin
      if (eknown) chk("coefdata", 32'(bus.coefdata), 32'(edata));
      chk("bank_sel", 32'(bus.bank_sel), 32'(msel));
      chk("ld_ready", 32'(bus.ld_ready), 32'(mready));
      chk("ld_done",  32'(bus.ld_done),  32'(mdone));
      chk("ld_error", 32'(bus.ld_error), 32'(merr));
    end
    // Predict outputs after the coming rising edge from the inputs now.
    if (reset) begin
      edata = 0; eknown = 1;
      msel = 0; mdone = 0; merr = 0;
      mloading = 0; mfull = 0; mpending = 0; mcnt = 0;
    end else begin
      if (int'(bus.coefaddress) < NT) begin
        eknown = mknown[msel][bus.coefaddress];
        edata  = mbank[msel][bus.coefaddress];
      end else begin
        eknown = 1; edata = 0;
      end
      mdone = 0; merr = 0;
      if (mloading) begin
        if (bus.commit) begin
          merr = 1; mloading = 0;
        end else if (bus.ld_start) begin
          mcnt = 0;
        end else if (bus.ld_valid && mready) begin
          mbank[!msel][mcnt]  = int'(bus.ld_data);
          mknown[!msel][mcnt] = 1;
          mcnt++;
          if (mcnt == NT) begin mloading = 0; mfull = 1; end
        end
      end else if (mfull) begin
        if (bus.commit) begin mfull = 0; mpending = 1; end
        else if (bus.ld_start) begin mfull = 0; mloading = 1; mcnt = 0; end
      end else if (mpending) begin
        if (bus.endata) begin mpending = 0; msel = !msel; mdone = 1; end
      end else if (bus.ld_start) begin
        mloading = 1; mcnt = 0;
      end
    end
    mready = mloading;
    mvalid = 1;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic load(input int base, input int n, input bit toggle);
    int i = 0;
    int cyc = 0;
    bit want = 1;
    bus.ld_start = 1; step(); bus.ld_start = 0;
    while (i < n && cyc < 400) begin
      if (bus.ld_ready && want) begin
        bus.ld_valid = 1; bus.ld_data = 18'(base + i); i++;
      end else begin
        bus.ld_valid = 0;
      end
      step(); cyc++;
      if (toggle) want = !want;
    end
    bus.ld_valid = 0;
    if (i < n) begin
      checks++; errors++;
      $display("FAIL load_timeout: got %0d words expected %0d", i, n);
    end
  endtask

  task automatic rd(input int a, input int exp, input string name);
    bus.coefaddress = 7'(a); step();
    chk(name, 32'(bus.coefdata), 32'(exp));
  endtask

  initial begin
    bus.coefaddress = '0; bus.endata = 0; bus.ld_start = 0;
    bus.ld_valid = 0; bus.ld_data = '0; bus.commit = 0;
    step(2);
    chk("rst_ready", 32'(bus.ld_ready), 0);
    chk("rst_sel",   32'(bus.bank_sel), 0);
    chk("rst_data",  32'(bus.coefdata), 0);
    reset = 0;

    // load and swap: words i+1, commit, endata 3 cycles later
    load(1, NT, 0);
    chk("full_ready", 32'(bus.ld_ready), 0);
    bus.commit = 1; step(); bus.commit = 0;
    step(2);
    bus.endata = 1; step(); bus.endata = 0;
    chk("swap_done", 32'(bus.ld_done), 1);
    chk("swap_sel",  32'(bus.bank_sel), 1);
    step();
    chk("done_pulse", 32'(bus.ld_done), 0);
    rd(0, 1, "rd0"); rd(32, 33, "rd32"); rd(64, 65, "rd64");

    // address bound
    rd(65, 0, "oob65"); rd(127, 0, "oob127");

    // swap isolation: endata while address 10 is presented
    load(1000, NT, 0);
    bus.commit = 1; step(); bus.commit = 0; step();
    for (int a = 0; a < NT; a++) begin
      bus.coefaddress = 7'(a);
      bus.endata = (a == 10);
      step();
      if (a == 10) begin
        chk("iso_old", 32'(bus.coefdata), 11);
        chk("iso_done", 32'(bus.ld_done), 1);
      end
      if (a == 11) chk("iso_new", 32'(bus.coefdata), 1011);
    end
    bus.endata = 0;

    // incomplete commit
    load(5000, 20, 0);
    bus.commit = 1; step(); bus.commit = 0;
    chk("inc_err", 32'(bus.ld_error), 1);
    chk("inc_sel", 32'(bus.bank_sel), 0);
    step();
    chk("inc_err_pulse", 32'(bus.ld_error), 0);
    chk("inc_idle_ready", 32'(bus.ld_ready), 0);
    rd(5, 1005, "inc_rd5");

    // restart then throttled full load
    load(7000, 30, 0);
    load(2000, NT, 1);
    chk("bp_ready", 32'(bus.ld_ready), 0);
    bus.commit = 1; step(); bus.commit = 0; step();
    bus.endata = 1; step(); bus.endata = 0;
    chk("bp_sel", 32'(bus.bank_sel), 1);
    rd(29, 2029, "bp_rd29"); rd(0, 2000, "bp_rd0"); rd(64, 2064, "bp_rd64");

    // reset while PENDING
    load(3000, NT, 0);
    bus.commit = 1; step(); bus.commit = 0; step();
    reset = 1; step(); reset = 0;
    bus.endata = 1; step(); bus.endata = 0;
    chk("rp_done",  32'(bus.ld_done), 0);
    chk("rp_sel",   32'(bus.bank_sel), 0);
    chk("rp_ready", 32'(bus.ld_ready), 0);
    rd(3, 3003, "rp_rd3");

    step(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
